// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared FSM state type and default operand width for the serial subtractor
package sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit full subtractor cell (d = a - b - borrow)
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bw_i,
  output logic d_o,
  output logic bw_o
);

  assign d_o  = a_i ^ b_i ^ bw_i;
  assign bw_o = (~a_i & b_i) | (~(a_i ^ b_i) & bw_i);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// rtl/serial_subtractor_ctrl.sv - bit-serial a - b - b_in, LSB first, one bit per cycle
// Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             bw_q;
  logic [WIDTH-2:0] sh_q;
  logic [WIDTH-1:0] diff_q;
  logic             b_out_q;

  logic [IW-1:0]    idx;
  logic             cell_d, cell_bw;
  logic             last_bit;
  logic [WIDTH-1:0] sh_next;

  assign idx      = cnt_q[IW-1:0];
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  // The partial result lives in sh_q; diff only changes once all bits are in.
  assign sh_next  = {cell_d, sh_q};

  full_subtractor u_cell (
    .a_i  (a_q[idx]),
    .b_i  (b_q[idx]),
    .bw_i (bw_q),
    .d_o  (cell_d),
    .bw_o (cell_bw)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && last_bit) begin
      ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (cell_d != a_q[WIDTH-1]);
    end
  end

  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bw_q    <= 1'b0;
      sh_q    <= '0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      a_q   <= a;
      b_q   <= b;
      bw_q  <= b_in;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      sh_q  <= sh_next[WIDTH-1:1];
      bw_q  <= cell_bw;
      cnt_q <= cnt_q + CW'(1);
      if (last_bit) begin
        diff_q  <= sh_next;
        b_out_q <= cell_bw;
      end
    end
  end

  assign diff  = diff_q;
  assign b_out = b_out_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb/tb_serial_subtractor_ctrl.sv - self-checking bench for serial_subtractor_ctrl (WIDTH=8)
module tb_serial_subtractor_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         b_in;
  logic         busy, done, b_out;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
  end

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer arithmetic; bit W of the wrapped result is the borrow.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic bi);
    int r;
    r = int'(x) - int'(y) - int'(bi);
    return r[W:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic bi);
    logic [W:0] r;
    r = ref_sub(x, y, bi);
    return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // Starts one operation from an IDLE cycle; returns in the first IDLE cycle after DONE.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                        input int pulse_at, input string tag);
    logic [W:0] expv;
    int dc0;
    expv = ref_sub(xa, xb, xbin);
    dc0  = done_cnt;
    a = xa; b = xb; b_in = xbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
    for (int k = 1; k <= W + 1; k++) begin
      if (k == pulse_at) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (k <= W) begin
        check({tag, " busy_run"}, busy, 1);
        check({tag, " done_early"}, done, 0);
      end else begin
        check({tag, " done"}, done, 1);
        check({tag, " diff"}, diff, expv[W-1:0]);
        check({tag, " b_out"}, b_out, expv[W]);
`ifdef SERIAL_SUB_OVF_EN
        check({tag, " ovf"}, ovf, ref_ovf(xa, xb, xbin));
`endif
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, " busy_idle"}, busy, 0);
    check({tag, " done_idle"}, done, 0);
    check({tag, " diff_hold"}, diff, expv[W-1:0]);
    check({tag, " b_out_hold"}, b_out, expv[W]);
    check({tag, " done_count"}, done_cnt - dc0, 1);
  endtask

  initial begin
    int dc0;
    int gap;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset diff", diff, 0);
    check("reset b_out", b_out, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset ovf", ovf, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8'h05, 8'h03, 1'b0, 0, "5-3");
    run_op(8'h03, 8'h05, 1'b0, 0, "3-5");
    run_op(8'h00, 8'h00, 1'b1, 0, "0-0-1");
    run_op(8'hA5, 8'h3C, 1'b0, 3, "start_in_run");
    run_op(8'h12, 8'h34, 1'b1, W + 1, "start_in_done");

    // Back-to-back: second start is driven in the first IDLE cycle after DONE.
    run_op(8'hFF, 8'h01, 1'b0, 0, "b2b_1");
    run_op(8'h10, 8'h20, 1'b0, 0, "b2b_2");
    gap = (done_cyc.size() >= 2) ? done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2] : -1;
    check("b2b done spacing", gap, W + 2);

    // Reset in the middle of RUN.
    run_op(8'h03, 8'h05, 1'b0, 0, "pre_rst");
    dc0 = done_cnt;
    a = 8'h77; b = 8'h11; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_run busy", busy, 0);
    check("rst_run done", done, 0);
    check("rst_run diff", diff, 0);
    check("rst_run b_out", b_out, 0);
    repeat (W + 4) @(posedge clk);
    #1;
    check("rst_run no_done", done_cnt - dc0, 0);
    run_op(8'h42, 8'h17, 1'b1, 0, "after_rst");

    // Reset and start together: start is lost.
    dc0 = done_cnt;
    rst = 1'b1; start = 1'b1; a = 8'h99; b = 8'h11;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_start busy", busy, 0);
    repeat (W + 3) @(posedge clk);
    #1;
    check("rst_start busy_later", busy, 0);
    check("rst_start no_done", done_cnt - dc0, 0);

`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, 1'b0, 0, "ovf_80-01");
    run_op(8'h05, 8'h03, 1'b0, 0, "ovf_05-03");
    run_op(8'h7F, 8'hFF, 1'b0, 0, "ovf_7F-FF");
`endif

    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, W + 1)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
